miniled_sdi_rx: RTL and testbench

//  Receive-side decoder for the LED driver serial link (DCLK/SDI/LE/scan1-4) produced by

---
 rtl/miniled_pkg.sv | 48 ++++
 rtl/miniled_sync_edge.sv | 30 +++
 rtl/miniled_sdi_rx.sv | 155 +++++++++++++++
 tb/tb_miniled_sdi_rx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miniled_pkg.sv
// Shared constants, command codes and helpers for the MiniLED serial link receiver.
package miniled_pkg;

    localparam int unsigned WORD_W        = 16;
    localparam int unsigned CHAIN_LEN     = 6;
    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned CMD_LATCH_MAX = 2;
    localparam int unsigned CMD_VSYNC_LEN = 3;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned BIT_CNT_W     = 4;
    localparam int unsigned LE_CNT_W      = 4;
    localparam int unsigned FRAME_W       = 16;
    localparam int unsigned SCAN_N        = 4;
    localparam int unsigned SCAN_W        = 2;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LATCH,
        CMD_VSYNC,
        CMD_OTHER
    } cmd_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } word_t;

    // LE pulse width (in DCLK edges) to command
    function automatic cmd_e classify_le(input logic [LE_CNT_W-1:0] n);
        if (n == LE_CNT_W'(CMD_VSYNC_LEN)) return CMD_VSYNC;
        if (n != '0 && n <= LE_CNT_W'(CMD_LATCH_MAX)) return CMD_LATCH;
        return CMD_OTHER;
    endfunction

    function automatic logic scan_multi(input logic [SCAN_N-1:0] s);
        return (s & (s - SCAN_N'(1))) != '0;
    endfunction

    function automatic logic [SCAN_W-1:0] scan_encode(input logic [SCAN_N-1:0] s);
        case (s)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/miniled_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses; level is aligned with the pulses.
module miniled_sync_edge #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            level  <= '0;
            rise   <= '0;
            fall   <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            level  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~level;
            fall   <= ~sync_q[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/miniled_sdi_rx.sv
// Receive-side decoder for the MiniLED DCLK/SDI/LE/scan link: words, LE commands, scan line.
module miniled_sdi_rx
    import miniled_pkg::*;
(
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                DCLK,
    input  logic                SDI,
    input  logic                LE,
    input  logic [SCAN_N-1:0]   scan_in,
    output logic                word_valid,
    output logic [WORD_W-1:0]   word_data,
    output logic [IDX_W-1:0]    word_idx,
    output logic                latch_valid,
    output logic                frame_valid,
    output logic                cmd_other,
    output logic [LE_CNT_W-1:0] le_width,
    output logic [FRAME_W-1:0]  frame_cnt,
    output logic [SCAN_W-1:0]   scan_line,
    output logic                err_align,
    output logic                err_scan
);

    // Reset: asynchronous assert, synchronous release
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic              dclk_rise, le_fall, le_lvl, sdi_lvl;
    logic [SCAN_N-1:0] scan_lvl;
    logic              unused_dclk_lvl, unused_dclk_fall, unused_le_rise;
    logic              unused_sdi_rise, unused_sdi_fall;
    logic [SCAN_N-1:0] unused_scan_rise, unused_scan_fall;

    miniled_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_dclk (
        .clk(I_clk), .rst_n(rst_n), .d(DCLK),
        .level(unused_dclk_lvl), .rise(dclk_rise), .fall(unused_dclk_fall));

    miniled_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_le (
        .clk(I_clk), .rst_n(rst_n), .d(LE),
        .level(le_lvl), .rise(unused_le_rise), .fall(le_fall));

    miniled_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(I_clk), .rst_n(rst_n), .d(SDI),
        .level(sdi_lvl), .rise(unused_sdi_rise), .fall(unused_sdi_fall));

    miniled_sync_edge #(.W(SCAN_N), .STAGES(SYNC_STAGES)) u_sync_scan (
        .clk(I_clk), .rst_n(rst_n), .d(scan_in),
        .level(scan_lvl), .rise(unused_scan_rise), .fall(unused_scan_fall));

    logic [WORD_W-1:0]   shifter, shifter_nx;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [IDX_W-1:0]    idx_cnt, idx_cnt_nx;
    logic [LE_CNT_W-1:0] le_cnt, le_cnt_nx, le_width_nx;
    logic [FRAME_W-1:0]  frame_cnt_nx;
    logic                done_v, done_nx, align_nx;
    word_t               done_word, done_word_nx;
    cmd_e                cmd_nx;

    // Edge handling: a DCLK rise is shifted and counted before a same-cycle LE fall is classified
    always_comb begin
        shifter_nx   = shifter;
        bit_cnt_nx   = bit_cnt;
        idx_cnt_nx   = idx_cnt;
        le_cnt_nx    = le_cnt;
        done_nx      = 1'b0;
        done_word_nx = done_word;
        cmd_nx       = CMD_NONE;
        align_nx     = 1'b0;
        le_width_nx  = le_width;
        frame_cnt_nx = frame_cnt;
        if (dclk_rise) begin
            shifter_nx = {shifter[WORD_W-2:0], sdi_lvl};
            if ((le_lvl || le_fall) && le_cnt != '1) le_cnt_nx = le_cnt + LE_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(WORD_W - 1)) begin
                done_nx           = 1'b1;
                done_word_nx.data = shifter_nx;
                done_word_nx.idx  = idx_cnt;
                idx_cnt_nx        = (idx_cnt == IDX_W'(CHAIN_LEN - 1)) ? '0 : idx_cnt + IDX_W'(1);
                bit_cnt_nx        = '0;
            end else begin
                bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
            end
        end
        if (le_fall) begin
            le_width_nx = le_cnt_nx;
            cmd_nx      = classify_le(le_cnt_nx);
            if (bit_cnt_nx != '0) begin
                align_nx   = 1'b1;
                bit_cnt_nx = '0;
                shifter_nx = '0;
            end
            if (cmd_nx == CMD_VSYNC) begin
                frame_cnt_nx = frame_cnt + FRAME_W'(1);
                idx_cnt_nx   = '0;
            end
            le_cnt_nx = '0;
        end
    end

    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter     <= '0;
            bit_cnt     <= '0;
            idx_cnt     <= '0;
            le_cnt      <= '0;
            done_v      <= 1'b0;
            done_word   <= '0;
            word_valid  <= 1'b0;
            word_data   <= '0;
            word_idx    <= '0;
            latch_valid <= 1'b0;
            frame_valid <= 1'b0;
            cmd_other   <= 1'b0;
            err_align   <= 1'b0;
            le_width    <= '0;
            frame_cnt   <= '0;
        end else begin
            shifter     <= shifter_nx;
            bit_cnt     <= bit_cnt_nx;
            idx_cnt     <= idx_cnt_nx;
            le_cnt      <= le_cnt_nx;
            done_v      <= done_nx;
            done_word   <= done_word_nx;
            word_valid  <= done_v;
            if (done_v) begin
                word_data <= done_word.data;
                word_idx  <= done_word.idx;
            end
            latch_valid <= (cmd_nx == CMD_LATCH);
            frame_valid <= (cmd_nx == CMD_VSYNC);
            cmd_other   <= (cmd_nx == CMD_OTHER);
            err_align   <= align_nx;
            le_width    <= le_width_nx;
            frame_cnt   <= frame_cnt_nx;
        end
    end

    // Scan decoder: blanking and multi-hot both hold the last valid line
    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_line <= '0;
            err_scan  <= 1'b0;
        end else begin
            err_scan <= scan_multi(scan_lvl);
            if (scan_lvl != '0 && !scan_multi(scan_lvl)) scan_line <= scan_encode(scan_lvl);
        end
    end

endmodule

// File: tb/tb_miniled_sdi_rx.sv
// Self-checking bench for miniled_sdi_rx: link-level reference model, scan table, corner sequences.
module tb_miniled_sdi_rx;
    import miniled_pkg::*;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        DCLK = 1'b0;
    logic        SDI = 1'b0;
    logic        LE = 1'b0;
    logic [3:0]  scan_in = 4'b0001;
    logic        word_valid;
    logic [15:0] word_data;
    logic [2:0]  word_idx;
    logic        latch_valid, frame_valid, cmd_other;
    logic [3:0]  le_width;
    logic [15:0] frame_cnt;
    logic [1:0]  scan_line;
    logic        err_align, err_scan;

    miniled_sdi_rx dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .DCLK(DCLK), .SDI(SDI), .LE(LE),
        .scan_in(scan_in), .word_valid(word_valid), .word_data(word_data),
        .word_idx(word_idx), .latch_valid(latch_valid), .frame_valid(frame_valid),
        .cmd_other(cmd_other), .le_width(le_width), .frame_cnt(frame_cnt),
        .scan_line(scan_line), .err_align(err_align), .err_scan(err_scan));

    always #5 I_clk = ~I_clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operates on link events (DCLK rises, LE falls), not on clock cycles
    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  idx;
    } exp_word_t;
    typedef struct packed {
        logic [1:0]  kind;   // 1 latch, 2 vsync, 3 other
        logic [3:0]  width;
        logic        err;
        logic [15:0] fcnt;
    } exp_cmd_t;

    exp_word_t   word_q[$];
    exp_cmd_t    cmd_q[$];
    int          m_bits, m_idx, m_le, m_fcnt;
    logic [15:0] m_shift;
    logic        le_cur = 1'b0;

    task automatic model_reset();
        m_bits = 0; m_idx = 0; m_le = 0; m_fcnt = 0; m_shift = '0;
        word_q.delete();
        cmd_q.delete();
    endtask

    task automatic model_rise(input logic b, input logic le_hi);
        exp_word_t w;
        m_shift = {m_shift[14:0], b};
        m_bits++;
        if (le_hi && m_le < 15) m_le++;
        if (m_bits == 16) begin
            w.data = m_shift;
            w.idx  = 3'(m_idx);
            word_q.push_back(w);
            m_idx  = (m_idx + 1) % 6;
            m_bits = 0;
        end
    endtask

    task automatic model_fall();
        exp_cmd_t c;
        if (m_le >= 1 && m_le <= 2) c.kind = 2'd1;
        else if (m_le == 3)         c.kind = 2'd2;
        else                        c.kind = 2'd3;
        c.width = 4'(m_le);
        c.err   = (m_bits != 0);
        if (c.kind == 2'd2) begin
            m_fcnt = (m_fcnt + 1) % 65536;
            m_idx  = 0;
        end
        c.fcnt = 16'(m_fcnt);
        cmd_q.push_back(c);
        if (c.err) begin
            m_bits  = 0;
            m_shift = '0;
        end
        m_le = 0;
    endtask

    // Output monitor / scoreboard
    exp_word_t ew;
    exp_cmd_t  ec;
    logic [1:0] obs_kind;
    always begin
        @(posedge I_clk);
        #1;
        if (word_valid) begin
            if (word_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL word_extra: got word 0x%h idx %0d, none expected", word_data, word_idx);
            end else begin
                ew = word_q.pop_front();
                check("word_data", 64'(word_data), 64'(ew.data));
                check("word_idx", 64'(word_idx), 64'(ew.idx));
            end
        end
        if (latch_valid || frame_valid || cmd_other || err_align) begin
            case ({latch_valid, frame_valid, cmd_other})
                3'b100:  obs_kind = 2'd1;
                3'b010:  obs_kind = 2'd2;
                3'b001:  obs_kind = 2'd3;
                default: obs_kind = 2'd0;
            endcase
            if (cmd_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL cmd_extra: got kind %0d width %0d, none expected", obs_kind, le_width);
            end else begin
                ec = cmd_q.pop_front();
                check("cmd_kind", 64'(obs_kind), 64'(ec.kind));
                check("le_width", 64'(le_width), 64'(ec.width));
                check("err_align", 64'(err_align), 64'(ec.err));
                check("frame_cnt", 64'(frame_cnt), 64'(ec.fcnt));
            end
        end
    end

    // Link drivers: DCLK period 8 I_clk, SDI/LE change while DCLK is low
    task automatic send_bit(input logic b, input logic le);
        @(negedge I_clk);
        if (le_cur && !le) model_fall();
        DCLK = 1'b0; SDI = b; LE = le; le_cur = le;
        repeat (4) @(negedge I_clk);
        DCLK = 1'b1;
        model_rise(b, le);
        repeat (3) @(negedge I_clk);
    endtask

    task automatic send_word(input logic [15:0] d, input int nl);
        for (int i = 15; i >= 0; i--) send_bit(d[i], i < nl);
    endtask

    task automatic coincident_fall(input logic b);
        @(negedge I_clk);
        DCLK = 1'b0; SDI = b; LE = 1'b1; le_cur = 1'b1;
        repeat (4) @(negedge I_clk);
        DCLK = 1'b1; LE = 1'b0;
        model_rise(b, 1'b1);
        model_fall();
        le_cur = 1'b0;
        repeat (3) @(negedge I_clk);
    endtask

    task automatic le_release();
        @(negedge I_clk);
        DCLK = 1'b0;
        if (le_cur) begin
            model_fall();
            LE = 1'b0; le_cur = 1'b0;
        end
        repeat (8) @(negedge I_clk);
    endtask

    task automatic le_pulse_no_edge();
        @(negedge I_clk);
        DCLK = 1'b0; LE = 1'b1; le_cur = 1'b1;
        repeat (6) @(negedge I_clk);
        LE = 1'b0; le_cur = 1'b0;
        model_fall();
        repeat (6) @(negedge I_clk);
    endtask

    task automatic send_word_lat(input logic [15:0] d);
        int k;
        for (int i = 15; i >= 1; i--) send_bit(d[i], 1'b0);
        @(negedge I_clk);
        DCLK = 1'b0; SDI = d[0]; LE = 1'b0;
        repeat (4) @(negedge I_clk);
        DCLK = 1'b1;
        model_rise(d[0], 1'b0);
        @(posedge I_clk);
        k = 0;
        for (int c = 1; c <= 12 && k == 0; c++) begin
            @(posedge I_clk);
            #1;
            if (word_valid) k = c;
        end
        check("word_latency", 64'(k), 64'(SYNC_STAGES + 2));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({word_valid, word_data, word_idx, latch_valid, frame_valid, cmd_other,
                    le_width, frame_cnt, scan_line, err_align, err_scan});
    endfunction

    typedef struct {
        logic [3:0] scan;
        logic [1:0] line;
        logic       err;
    } scan_vec_t;
    scan_vec_t scan_tbl[9];

    initial begin
        repeat (90000) @(posedge I_clk);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nl;
        logic b, coin;

        scan_tbl[0] = '{4'b0001, 2'd0, 1'b0};
        scan_tbl[1] = '{4'b0000, 2'd0, 1'b0};
        scan_tbl[2] = '{4'b0100, 2'd2, 1'b0};
        scan_tbl[3] = '{4'b0110, 2'd2, 1'b1};
        scan_tbl[4] = '{4'b1000, 2'd3, 1'b0};
        scan_tbl[5] = '{4'b0000, 2'd3, 1'b0};
        scan_tbl[6] = '{4'b0010, 2'd1, 1'b0};
        scan_tbl[7] = '{4'b1011, 2'd1, 1'b1};
        scan_tbl[8] = '{4'b0001, 2'd0, 1'b0};

        model_reset();
        repeat (3) @(negedge I_clk);
        check("reset_outputs", all_outputs(), 64'd0);
        I_rst_n = 1'b1;
        repeat (6) @(negedge I_clk);

        // Six words then a one-edge latch on the last bit
        for (int w = 1; w <= 6; w++) send_word(16'(w), (w == 6) ? 1 : 0);
        le_release();
        check("latch_le_width", 64'(le_width), 64'd1);
        check("latch_frame_cnt", 64'(frame_cnt), 64'd0);

        // Seven words (index wraps), then a three-edge vsync
        for (int w = 0; w < 7; w++) send_word(16'($urandom), 0);
        send_word(16'h3C5A, 3);
        le_release();
        check("vsync_frame_cnt", 64'(frame_cnt), 64'd1);

        // Partial word under a latch: alignment error, then a clean word
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        le_release();
        send_word(16'hFFFF, 0);
        le_release();

        // Long LE saturates the width counter
        send_word(16'h1357, 4);
        send_word(16'h2468, 16);
        le_release();
        check("long_le_width", 64'(le_width), 64'd15);

        // LE falls on the same sample as the third DCLK rise
        send_word(16'hBEEF >> 3, 0);
        for (int i = 0; i < 13; i++) send_bit(1'($urandom), 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        coincident_fall(1'b1);
        le_release();
        check("coincident_le_width", 64'(le_width), 64'd3);
        check("coincident_frame_cnt", 64'(frame_cnt), 64'd2);

        le_pulse_no_edge();
        check("zero_width_le", 64'(le_width), 64'd0);

        send_word_lat(16'hC0DE);
        le_release();

        // Randomized link traffic
        for (int it = 0; it < 40; it++) begin
            nb   = int'($urandom_range(40, 1));
            nl   = int'($urandom_range((nb < 18) ? nb : 18, 0));
            coin = (nl > 0) && ($urandom_range(3, 0) == 0);
            for (int i = 0; i < nb; i++) begin
                b = 1'($urandom);
                if (coin && i == nb - 1) coincident_fall(b);
                else                     send_bit(b, i >= nb - nl);
            end
            le_release();
            if ($urandom_range(4, 0) == 0) le_pulse_no_edge();
        end
        repeat (10) @(negedge I_clk);
        check("pending_words", 64'(word_q.size()), 64'd0);
        check("pending_cmds", 64'(cmd_q.size()), 64'd0);

        // Reset in the middle of a word
        for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b0);
        @(negedge I_clk);
        DCLK = 1'b0;
        I_rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge I_clk);
        check("midword_reset_outputs", all_outputs(), 64'd0);
        I_rst_n = 1'b1;
        repeat (6) @(negedge I_clk);
        send_word(16'hA5C3, 0);
        le_release();
        check("post_reset_pending", 64'(word_q.size()), 64'd0);

        // Scan decoder table
        for (int i = 0; i < 9; i++) begin
            @(negedge I_clk);
            scan_in = scan_tbl[i].scan;
            repeat (6) @(negedge I_clk);
            check("scan_line", 64'(scan_line), 64'(scan_tbl[i].line));
            check("err_scan", 64'(err_scan), 64'(scan_tbl[i].err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
